countdown_timer: RTL and testbench

Hours/minutes/seconds countdown timer, the down-counting counterpart to the free-running time-of-day clock. Software or a front-panel controller loads an hh:mm:ss value, starts the timer, and may pause it. The timer decrements once per second tick, borrowing across the fields, and flags expiry when it reaches 00:00:00. Its outputs use the same field widths as the time-of-day clock, so both can share the display path.

---
 rtl/timer_pkg.sv | 54 +++++
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_tick.sv | 37 +++
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types, field widths and hh:mm:ss helpers for the countdown timer and
// the time-of-day clock display path.
package timer_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } hms_t;

  // Saturate each field to its legal maximum.
  function automatic hms_t clamp_hms(hms_t v);
    hms_t r;
    r = v;
    if (v.hour > HOUR_W'(HOUR_MAX)) r.hour = HOUR_W'(HOUR_MAX);
    if (v.min  > MIN_W'(MIN_MAX))   r.min  = MIN_W'(MIN_MAX);
    if (v.sec  > SEC_W'(SEC_MAX))   r.sec  = SEC_W'(SEC_MAX);
    return r;
  endfunction

  // One-second decrement with borrow; never called on 00:00:00.
  function automatic hms_t dec_hms(hms_t v);
    hms_t r;
    r = v;
    if (v.sec != '0) begin
      r.sec = v.sec - SEC_W'(1);
    end else begin
      r.sec = SEC_W'(SEC_MAX);
      if (v.min != '0) begin
        r.min = v.min - MIN_W'(1);
      end else begin
        r.min  = MIN_W'(MIN_MAX);
        r.hour = v.hour - HOUR_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command and status bundle between a controller and the countdown timer.
interface countdown_timer_if;
  import timer_pkg::*;

  logic              load;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [SEC_W-1:0]  load_sec;
  logic              start;
  logic              pause;

  logic [HOUR_W-1:0] hour_cnt;
  logic [MIN_W-1:0]  min_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic              running;
  logic              expired;
  logic              done;

  modport master (
    output load, load_hour, load_min, load_sec, start, pause,
    input  hour_cnt, min_cnt, sec_cnt, running, expired, done
  );

  modport slave (
    input  load, load_hour, load_min, load_sec, start, pause,
    output hour_cnt, min_cnt, sec_cnt, running, expired, done
  );

endinterface

// File: rtl/countdown_tick.sv
// One-second tick divider: counts 0..TICK_DIV-1 while enabled, ticks on the
// last count and wraps. A held (disabled) divider keeps its value.
module countdown_tick #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;

  assign tick = en && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = tick ? '0 : div_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer: load/start/pause control FSM, borrow chain and
// expiry flagging, driven by a one-second tick divider.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  state_e state_q, state_d;
  hms_t   cnt_q, cnt_d;
  logic   done_q, done_d;
  logic   running_q;
  logic   expired_q;

  hms_t   load_val;
  logic   tick;
  logic   div_clr;
  logic   div_en;

  assign load_val = clamp_hms({bus.load_hour, bus.load_min, bus.load_sec});

  // Pause gates the divider on its own edge so a coincident tick stays pending.
  assign div_clr = bus.load || ((state_q == ST_IDLE) && bus.start);
  assign div_en  = (state_q == ST_RUN) && !bus.pause;

  countdown_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bus.load) begin
      state_d = ST_IDLE;
      cnt_d   = load_val;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (bus.start) begin
            if (cnt_q == '0) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            cnt_d = dec_hms(cnt_q);
            if (cnt_d == '0) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign bus.hour_cnt = cnt_q.hour;
  assign bus.min_cnt  = cnt_q.min;
  assign bus.sec_cnt  = cnt_q.sec;
  assign bus.running  = running_q;
  assign bus.expired  = expired_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with a 4-cycle tick: expected output
// snapshots are queued per clock edge and compared just after that edge.
module tb_countdown_timer;

  localparam int unsigned TDIV = 4;

  typedef struct {
    int         cyc;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       run;
    logic       ex;
    logic       dn;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  countdown_timer_if bus ();

  countdown_timer #(
    .TICK_DIV (TDIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic void expect_at(input int c, input int h, input int m, input int s,
                                    input bit run, input bit ex, input bit dn);
    exp_t e;
    e.cyc = c;
    e.h   = 5'(h);
    e.m   = 6'(m);
    e.s   = 6'(s);
    e.run = run;
    e.ex  = ex;
    e.dn  = dn;
    sb.push_back(e);
  endfunction

  // Edge counter and scoreboard consumer, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("c%0d.hour", e.cyc), 32'(bus.hour_cnt), 32'(e.h));
      check_eq($sformatf("c%0d.min",  e.cyc), 32'(bus.min_cnt),  32'(e.m));
      check_eq($sformatf("c%0d.sec",  e.cyc), 32'(bus.sec_cnt),  32'(e.s));
      check_eq($sformatf("c%0d.running", e.cyc), 32'(bus.running), 32'(e.run));
      check_eq($sformatf("c%0d.expired", e.cyc), 32'(bus.expired), 32'(e.ex));
      check_eq($sformatf("c%0d.done", e.cyc), 32'(bus.done), 32'(e.dn));
    end
  end

  // All drivers are entered at a negedge and return at a negedge.
  task automatic do_load(input int h, input int m, input int s);
    bus.load      = 1'b1;
    bus.load_hour = 5'(h);
    bus.load_min  = 6'(m);
    bus.load_sec  = 6'(s);
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int e;
    int r;
    cyc           = 0;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.load_hour = '0;
    bus.load_min  = '0;
    bus.load_sec  = '0;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    repeat (2) @(negedge clk);
    expect_at(cyc + 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc + 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Basic count 00:00:03 to expiry
    expect_at(cyc + 1, 0, 0, 3, 0, 0, 0);
    do_load(0, 0, 3);
    e = cyc + 1;
    expect_at(e,      0, 0, 3, 1, 0, 0);
    expect_at(e + 3,  0, 0, 3, 1, 0, 0);
    expect_at(e + 4,  0, 0, 2, 1, 0, 0);
    expect_at(e + 8,  0, 0, 1, 1, 0, 0);
    expect_at(e + 11, 0, 0, 1, 1, 0, 0);
    expect_at(e + 12, 0, 0, 0, 0, 1, 1);
    expect_at(e + 13, 0, 0, 0, 0, 1, 0);
    expect_at(e + 20, 0, 0, 0, 0, 1, 0);
    do_start();
    wait_until(e + 20);

    // Borrow chain 01:00:00 -> 00:59:59; load also clears expired
    expect_at(cyc + 1, 1, 0, 0, 0, 0, 0);
    do_load(1, 0, 0);
    e = cyc + 1;
    expect_at(e,     1, 0, 0, 1, 0, 0);
    expect_at(e + 4, 0, 59, 59, 1, 0, 0);
    do_start();
    wait_until(e + 4);

    // Pause and resume keeps the divider phase
    expect_at(cyc + 1, 0, 0, 5, 0, 0, 0);
    do_load(0, 0, 5);
    e = cyc + 1;
    expect_at(e,      0, 0, 5, 1, 0, 0);
    expect_at(e + 3,  0, 0, 5, 0, 0, 0);
    expect_at(e + 15, 0, 0, 5, 0, 0, 0);
    do_start();
    wait_until(e + 2);
    do_pause();
    repeat (20) @(negedge clk);
    r = cyc + 1;
    expect_at(r,     0, 0, 5, 1, 0, 0);
    expect_at(r + 1, 0, 0, 5, 1, 0, 0);
    expect_at(r + 2, 0, 0, 4, 1, 0, 0);
    expect_at(r + 5, 0, 0, 4, 1, 0, 0);
    expect_at(r + 6, 0, 0, 3, 1, 0, 0);
    do_start();
    wait_until(r + 6);

    // Field clamping on load
    expect_at(cyc + 1, 23, 59, 59, 0, 0, 0);
    do_load(30, 63, 60);
    expect_at(cyc + 1, 23, 59, 59, 0, 0, 0);
    do_load(24, 60, 63);
    expect_at(cyc + 1, 12, 59, 0, 0, 0, 0);
    do_load(12, 61, 0);

    // Start at zero expires immediately, single done pulse
    expect_at(cyc + 1, 0, 0, 0, 0, 0, 0);
    do_load(0, 0, 0);
    e = cyc + 1;
    expect_at(e,     0, 0, 0, 0, 1, 1);
    expect_at(e + 1, 0, 0, 0, 0, 1, 0);
    do_start();
    repeat (2) @(negedge clk);
    e = cyc + 1;
    expect_at(e,     0, 0, 0, 0, 1, 0);
    expect_at(e + 1, 0, 0, 0, 0, 1, 0);
    do_start();
    wait_until(e + 1);

    // Load coinciding with a tick wins, no decrement
    expect_at(cyc + 1, 0, 0, 3, 0, 0, 0);
    do_load(0, 0, 3);
    e = cyc + 1;
    expect_at(e + 3, 0, 0, 3, 1, 0, 0);
    expect_at(e + 4, 0, 0, 9, 0, 0, 0);
    expect_at(e + 8, 0, 0, 9, 0, 0, 0);
    do_start();
    wait_until(e + 3);
    do_load(0, 0, 9);
    wait_until(e + 8);

    // Pause coinciding with a tick wins; the pending tick fires on resume
    expect_at(cyc + 1, 0, 0, 7, 0, 0, 0);
    do_load(0, 0, 7);
    e = cyc + 1;
    expect_at(e + 3, 0, 0, 7, 1, 0, 0);
    expect_at(e + 4, 0, 0, 7, 0, 0, 0);
    expect_at(e + 6, 0, 0, 7, 0, 0, 0);
    do_start();
    wait_until(e + 3);
    do_pause();
    wait_until(e + 6);
    r = cyc + 1;
    expect_at(r,     0, 0, 7, 1, 0, 0);
    expect_at(r + 1, 0, 0, 6, 1, 0, 0);
    do_start();
    wait_until(r + 1);

    // Reset mid-run returns to IDLE with zero count
    expect_at(cyc + 1, 2, 3, 4, 0, 0, 0);
    do_load(2, 3, 4);
    e = cyc + 1;
    expect_at(e + 4, 2, 3, 3, 1, 0, 0);
    expect_at(e + 5, 0, 0, 0, 0, 0, 0);
    do_start();
    wait_until(e + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc + 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    e = cyc + 1;
    expect_at(e, 0, 0, 0, 0, 1, 1);
    do_start();
    wait_until(e + 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
